// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shift unit: op codes, op width and level-to-stage mapping.
// Rotates are enabled with the SHIFT_ROTATE_EN macro.
package shift_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    SHIFT_SLL = 3'b000,
    SHIFT_SRL = 3'b001,
    SHIFT_SRA = 3'b010,
    SHIFT_ROL = 3'b011,
    SHIFT_ROR = 3'b100
  } shift_op_e;

  // Pipeline stage that owns shifter level k.
  function automatic int stage_of_level(input int k, input int stages, input int shamt_w);
    return (k * stages) / shamt_w;
  endfunction

  function automatic logic op_unsupported(input logic [OP_W-1:0] op);
`ifdef SHIFT_ROTATE_EN
    return (op > SHIFT_ROR);
`else
    return (op > SHIFT_SRA);
`endif
  endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational level of the log shifter: shifts or rotates by 2^K when enabled.
// Rotate paths exist only when SHIFT_ROTATE_EN is defined.
module shift_level
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic             fill_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int SH = 1 << K;

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (op_i)
        SHIFT_SLL:            data_o = {data_i[WIDTH-SH-1:0], {SH{1'b0}}};
        SHIFT_SRL, SHIFT_SRA: data_o = {{SH{fill_i}}, data_i[WIDTH-1:SH]};
`ifdef SHIFT_ROTATE_EN
        SHIFT_ROL:            data_o = {data_i[WIDTH-SH-1:0], data_i[WIDTH-1:WIDTH-SH]};
        SHIFT_ROR:            data_o = {data_i[SH-1:0], data_i[WIDTH-1:SH]};
`endif
        // Unsupported ops pass through; the final stage forces them to zero.
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_shift_unit.sv
// Pipelined SLL/SRL/SRA (and ROL/ROR with SHIFT_ROTATE_EN) shift unit with valid/ready on
// both sides; log-shifter levels are spread over STAGES register stages with a global stall.
module alu_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             out_err
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic [STAGES-1:0]  valid_q;
  logic [WIDTH-1:0]   data_q   [STAGES];
  logic [OP_W-1:0]    op_q     [STAGES];
  logic [SHAMT_W-1:0] amt_q    [STAGES];
  logic               fill_q   [STAGES];
  logic               zero_q;
  logic               err_q;

  logic [OP_W-1:0]    op_src   [STAGES];
  logic [SHAMT_W-1:0] amt_src  [STAGES];
  logic               fill_src [STAGES];
  logic [WIDTH-1:0]   raw_d    [STAGES];
  logic [WIDTH-1:0]   data_d   [STAGES];

  logic [WIDTH-1:0]   lvl_in   [SHAMT_W];
  logic [WIDTH-1:0]   lvl_out  [SHAMT_W];

  logic               last_err;
  logic               unused_in2;

  assign unused_in2 = ^in_2[WIDTH-1:SHAMT_W];

  // Control fields each stage's levels see: raw inputs for stage 0, registered copies after.
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_src
      if (gi == 0) begin : g_first
        assign op_src[gi]   = in_op;
        assign amt_src[gi]  = in_2[SHAMT_W-1:0];
        assign fill_src[gi] = (in_op == SHIFT_SRA) & in_1[WIDTH-1];
      end else begin : g_rest
        assign op_src[gi]   = op_q[gi-1];
        assign amt_src[gi]  = amt_q[gi-1];
        assign fill_src[gi] = fill_q[gi-1];
      end
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_lvl
      localparam int S = stage_of_level(gi, STAGES, SHAMT_W);
      localparam bit FIRST = (gi == 0) ? 1'b1 : (stage_of_level(gi - 1, STAGES, SHAMT_W) != S);
      localparam bit LAST  = (gi == SHAMT_W - 1) ? 1'b1 : (stage_of_level(gi + 1, STAGES, SHAMT_W) != S);

      if (gi == 0) begin : g_in_op
        assign lvl_in[gi] = in_1;
      end else if (FIRST) begin : g_in_reg
        assign lvl_in[gi] = data_q[S-1];
      end else begin : g_in_chain
        assign lvl_in[gi] = lvl_out[gi-1];
      end

      shift_level #(
        .WIDTH (WIDTH),
        .K     (gi)
      ) u_level (
        .data_i (lvl_in[gi]),
        .op_i   (op_src[S]),
        .fill_i (fill_src[S]),
        .en_i   (amt_src[S][gi]),
        .data_o (lvl_out[gi])
      );

      if (LAST) begin : g_tap
        assign raw_d[S] = lvl_out[gi];
      end
    end
  endgenerate

  assign last_err = op_unsupported(op_src[STAGES-1]);

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_mask
      if (gi == STAGES - 1) begin : g_final
        assign data_d[gi] = last_err ? '0 : raw_d[gi];
      end else begin : g_mid
        assign data_d[gi] = raw_d[gi];
      end
    end
  endgenerate

  assign out_valid = valid_q[STAGES-1];
  assign in_ready  = !out_valid || out_ready;
  assign out       = data_q[STAGES-1];
  assign out_zero  = zero_q;
  assign out_err   = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
        op_q[s]   <= '0;
        amt_q[s]  <= '0;
        fill_q[s] <= 1'b0;
      end
    end else if (in_ready) begin
      valid_q[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) begin
        valid_q[s] <= valid_q[s-1];
      end
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= data_d[s];
        op_q[s]   <= op_src[s];
        amt_q[s]  <= amt_src[s];
        fill_q[s] <= fill_src[s];
      end
      zero_q <= (data_d[STAGES-1] == '0);
      err_q  <= last_err;
    end
  end

endmodule
